mem_stage: RTL

Memory-access stage of the five-stage MIPS pipeline. Sits between the EX stage and the WB stage: it takes the ALU result and control bits from EX, performs the data-memory load or store, and registers everything the WB stage consumes. When a memory access needs more than one cycle, it stalls the pipeline upstream.

---
 rtl/mem_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// MIPS memory-access stage: data memory load/store plus the MEM/WB output register.
// Optional wait-state FSM compiled in when MEM_WAIT_EN is defined.
module mem_stage #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        MemToRegIn,
    input  logic        regWriteIn,
    input  logic [31:0] ALUresultIn,
    input  logic [31:0] storeData,
    input  logic [4:0]  Destination_in,
    output logic        stall,
    output logic        MemToReg,
    output logic        regWriteOut,
    output logic [31:0] memData,
    output logic [31:0] ALUresult,
    output logic [4:0]  Destination_out,
    output logic        misalign
);

    localparam int AW = $clog2(DEPTH_WORDS);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("mem_stage: WAIT_STATES must be within 0..15");
    end

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [AW-1:0] w_idx;
    logic          w_memop;
    logic          w_mis;
    logic          w_load;
    logic          w_we;
    logic          w_stall_fsm;
    logic          w_stall;

    logic          r_MemToReg;
    logic          r_regWrite;
    logic [31:0]   r_memData;
    logic [31:0]   r_ALUresult;
    logic [4:0]    r_dest;
    logic          r_misalign;

    assign w_idx   = ALUresultIn[AW+1:2];
    assign w_memop = memRead | memWrite;
    assign w_mis   = w_memop & (ALUresultIn[1:0] != 2'b00);
    // A simultaneous read+write is treated as a store, so no load data.
    assign w_load  = memRead & ~memWrite & ~w_mis;

`ifdef MEM_WAIT_EN
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [3:0] LP_CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic       LP_HAS_WAIT = (WAIT_STATES > 0);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_memop && LP_HAS_WAIT) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = LP_CNT_INIT;
                end
            end
            S_WAIT: begin
                if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
                else               w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_stall_fsm = 1'b0;
        case (r_state)
            S_IDLE:  w_stall_fsm = w_memop & LP_HAS_WAIT;
            S_WAIT:  w_stall_fsm = (r_cnt != 4'd0);
            default: w_stall_fsm = 1'b0;
        endcase
    end
`else
    assign w_stall_fsm = 1'b0;
`endif

    assign w_stall = w_stall_fsm & ~rst;
    assign stall   = w_stall;
    assign w_we    = memWrite & ~w_mis & ~w_stall;

    // Stalled edges load a bubble so WB never sees the same op twice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_MemToReg  <= 1'b0;
            r_regWrite  <= 1'b0;
            r_memData   <= 32'd0;
            r_ALUresult <= 32'd0;
            r_dest      <= 5'd0;
            r_misalign  <= 1'b0;
        end else begin
            if (w_stall) begin
                r_MemToReg  <= 1'b0;
                r_regWrite  <= 1'b0;
                r_memData   <= 32'd0;
                r_ALUresult <= 32'd0;
                r_dest      <= 5'd0;
                r_misalign  <= 1'b0;
            end else begin
                r_MemToReg  <= MemToRegIn;
                r_regWrite  <= regWriteIn;
                r_memData   <= w_load ? r_mem[w_idx] : 32'd0;
                r_ALUresult <= ALUresultIn;
                r_dest      <= Destination_in;
                r_misalign  <= w_mis;
            end
            if (w_we) r_mem[w_idx] <= storeData;
        end
    end

    assign MemToReg        = r_MemToReg;
    assign regWriteOut     = r_regWrite;
    assign memData         = r_memData;
    assign ALUresult       = r_ALUresult;
    assign Destination_out = r_dest;
    assign misalign        = r_misalign;

endmodule
